// File: rtl/key_repeat_counter.sv
// key_repeat_counter
//   Up/down counter driven by two active-low board keys (up and down), each
//   with its own synchroniser, debounce filter and press/hold/auto-repeat FSM.
//   Counter is WIDTH bits, wraps (MODE=0) or saturates (MODE=1).
// Ports
//   FPGA_CLK   in   system clock, rising edge
//   RESET_BUT  in   synchronous active-high reset
//   KEY_UP_N   in   async up key, 0 = pressed
//   KEY_DN_N   in   async down key, 0 = pressed
//   clr        in   synchronous clear to INIT
//   count      out  registered counter value
//   inc_pulse  out  1-cycle strobe, count just incremented
//   dec_pulse  out  1-cycle strobe, count just decremented
//   at_max     out  count == all ones
//   at_min     out  count == 0

// Per-key conditioning: 2-FF sync, debounce, press/hold/repeat FSM.
// o_step is a registered 1-cycle strobe per accepted step.
module key_repeat_key #(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int HOLD_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int TW           = 26
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_step
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);

  logic [1:0]    r_sync;      // [1] is the synchronised level
  logic          r_stable_n;  // debounced key level, 1 = released
  logic [TW-1:0] r_deb;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_step;

  // Synchroniser and debounce filter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync     <= 2'b11;
      r_stable_n <= 1'b1;
      r_deb      <= '0;
    end else begin
      r_sync <= {r_sync[0], i_key_n};
      if (r_sync[1] == r_stable_n) begin
        r_deb <= '0;
      end else if (r_deb == DEB_LAST) begin
        r_deb      <= '0;
        r_stable_n <= r_sync[1];
      end else begin
        r_deb <= r_deb + 1'b1;
      end
    end
  end

  // Press / hold / repeat FSM. A release in any state wins. Entering
  // IDLE requires a release, so "pressed while IDLE" is a press edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_step  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (r_stable_n) begin
        r_state <= S_IDLE;
        r_timer <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_step  <= 1'b1;
            r_timer <= '0;
            r_state <= S_HOLD;
          end
          S_HOLD: begin
            if (r_timer == HOLD_LAST) begin
              r_step  <= 1'b1;
              r_timer <= '0;
              r_state <= S_REPEAT;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_REPEAT: begin
            if (r_timer == REP_LAST) begin
              r_step  <= 1'b1;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

  assign o_step = r_step;
endmodule

module key_repeat_counter #(
  parameter int WIDTH        = 4,
  parameter int MODE         = 0,
  parameter int INIT         = 0,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int HOLD_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000
) (
  input  logic             FPGA_CLK,
  input  logic             RESET_BUT,
  input  logic             KEY_UP_N,
  input  logic             KEY_DN_N,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             at_max,
  output logic             at_min
);
  localparam int NUM_KEYS = 2;
  localparam int M1   = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int MAXC = (M1 > DEBOUNCE_CYC) ? M1 : DEBOUNCE_CYC;
  localparam int TW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN  = '0;

  logic [NUM_KEYS-1:0] w_key_n;  // [0] up, [1] down
  logic [NUM_KEYS-1:0] w_step;
  logic [WIDTH-1:0]    r_count;
  logic                r_inc;
  logic                r_dec;

  assign w_key_n = {KEY_DN_N, KEY_UP_N};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_repeat_key #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .TW          (TW)
    ) u_key (
      .i_clk  (FPGA_CLK),
      .i_rst  (RESET_BUT),
      .i_key_n(w_key_n[g]),
      .o_step (w_step[g])
    );
  end

  // Simultaneous up and down cancel; saturating mode drops steps at the rails
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      r_count <= CNT_INIT;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      if (clr) begin
        r_count <= CNT_INIT;
      end else if (w_step[0] && !w_step[1]) begin
        if (MODE == 0 || r_count != CNT_MAX) begin
          r_count <= r_count + 1'b1;
          r_inc   <= 1'b1;
        end
      end else if (w_step[1] && !w_step[0]) begin
        if (MODE == 0 || r_count != CNT_MIN) begin
          r_count <= r_count - 1'b1;
          r_dec   <= 1'b1;
        end
      end
    end
  end

  assign count     = r_count;
  assign inc_pulse = r_inc;
  assign dec_pulse = r_dec;
  assign at_max    = (r_count == CNT_MAX);
  assign at_min    = (r_count == CNT_MIN);
endmodule

// File: tb/tb_key_repeat_counter.sv
module tb_key_repeat_counter;
  localparam int W    = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int INIT = 0;
  localparam int MOD  = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kup = 1'b1;
  logic kdn = 1'b1;
  logic clr = 1'b0;
  logic [W-1:0] cnt0, cnt1;
  logic inc0, dec0, max0, min0, inc1, dec1, max1, min1;

  always #5 clk = ~clk;

  key_repeat_counter #(.WIDTH(W), .MODE(0), .INIT(INIT), .DEBOUNCE_CYC(DEB),
                       .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) u_dut0 (
    .FPGA_CLK(clk), .RESET_BUT(rst), .KEY_UP_N(kup), .KEY_DN_N(kdn), .clr(clr),
    .count(cnt0), .inc_pulse(inc0), .dec_pulse(dec0), .at_max(max0), .at_min(min0));

  key_repeat_counter #(.WIDTH(W), .MODE(1), .INIT(INIT), .DEBOUNCE_CYC(DEB),
                       .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) u_dut1 (
    .FPGA_CLK(clk), .RESET_BUT(rst), .KEY_UP_N(kup), .KEY_DN_N(kdn), .clr(clr),
    .count(cnt1), .inc_pulse(inc1), .dec_pulse(dec1), .at_max(max1), .at_min(min1));

  typedef struct {int up; int cnt;} pulse_t;
  pulse_t q0[$];
  pulse_t q1[$];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Works on the key's pin history and the time since a
  // press was accepted: a key is accepted after DEB consecutive samples
  // disagreeing with its debounced level (pin seen through two flops); steps
  // then land on the count 2 edges after acceptance, then HOLD later, then
  // every REP while the debounced level stays pressed.
  int  cyc = 0;
  bit  p1[2]  = '{1, 1};
  bit  p2[2]  = '{1, 1};
  bit  stb[2] = '{1, 1};
  bit  sh1[2] = '{1, 1};
  bit  sh2[2] = '{1, 1};
  int  run[2] = '{0, 0};
  int  pe[2]  = '{-1000, -1000};
  int  mcnt[2] = '{INIT, INIT};

  initial forever begin
    @(negedge clk);
    cyc++;
    begin
      bit pin[2];
      bit st[2];
      pin[0] = kup;
      pin[1] = kdn;
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          p1[k] = 1; p2[k] = 1; stb[k] = 1; sh1[k] = 1; sh2[k] = 1;
          run[k] = 0; pe[k] = -1000;
        end
        mcnt[0] = INIT;
        mcnt[1] = INIT;
      end else begin
        for (int k = 0; k < 2; k++) begin
          int d;
          d = cyc - 2 - pe[k];
          st[k] = !sh2[k] && (d == 0 || (d >= HOLD && (d - HOLD) % REP == 0));
          if (p2[k] != stb[k]) begin
            run[k]++;
            if (run[k] == DEB) begin
              stb[k] = !stb[k];
              run[k] = 0;
              if (!stb[k]) pe[k] = cyc;
            end
          end else begin
            run[k] = 0;
          end
          sh2[k] = sh1[k]; sh1[k] = stb[k];
          p2[k]  = p1[k];  p1[k]  = pin[k];
        end
        if (clr) begin
          mcnt[0] = INIT;
          mcnt[1] = INIT;
        end else if (st[0] != st[1]) begin
          // wrapping instance
          mcnt[0] = st[0] ? (mcnt[0] + 1) % MOD : (mcnt[0] + MOD - 1) % MOD;
          q0.push_back('{up: int'(st[0]), cnt: mcnt[0]});
          // saturating instance
          if (st[0] && mcnt[1] != MOD - 1) begin
            mcnt[1]++;
            q1.push_back('{up: 1, cnt: mcnt[1]});
          end else if (st[1] && mcnt[1] != 0) begin
            mcnt[1]--;
            q1.push_back('{up: 0, cnt: mcnt[1]});
          end
        end
      end
    end
  end

  // Monitor: every pulse must match the head of its queue; a queued
  // expectation with no pulse is a missed step.
  initial forever begin
    @(posedge clk);
    #1;
    chk("count0", cnt0, mcnt[0]);
    chk("count1", cnt1, mcnt[1]);
    chk("at_max0", max0, mcnt[0] == MOD - 1);
    chk("at_min0", min0, mcnt[0] == 0);
    chk("at_max1", max1, mcnt[1] == MOD - 1);
    chk("at_min1", min1, mcnt[1] == 0);
    chk("both_pulses0", inc0 & dec0, 0);
    chk("both_pulses1", inc1 & dec1, 0);
    if (inc0 || dec0) begin
      if (q0.size() == 0) chk("spurious_pulse0", 1, 0);
      else begin
        pulse_t e;
        e = q0.pop_front();
        chk("pulse_dir0", inc0, e.up);
        chk("pulse_cnt0", cnt0, e.cnt);
      end
    end else if (q0.size() != 0) begin
      void'(q0.pop_front());
      chk("missed_pulse0", 0, 1);
    end
    if (inc1 || dec1) begin
      if (q1.size() == 0) chk("spurious_pulse1", 1, 0);
      else begin
        pulse_t e;
        e = q1.pop_front();
        chk("pulse_dir1", inc1, e.up);
        chk("pulse_cnt1", cnt1, e.cnt);
      end
    end else if (q1.size() != 0) begin
      void'(q1.pop_front());
      chk("missed_pulse1", 0, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // which: 1 = up, 2 = down, 3 = both
  task automatic press(input int which, input int n);
    kup = !(which == 1 || which == 3);
    kdn = !(which == 2 || which == 3);
    tick(n);
    kup = 1'b1;
    kdn = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int base0;
    int base1;
    int n;
    // 1: reset with the up key already held, then one step after release
    kup = 1'b0;
    tick(2);
    chk("rst_count", cnt0, 0);
    chk("rst_inc", inc0, 0);
    chk("rst_dec", dec0, 0);
    chk("rst_at_min", min0, 1);
    rst = 1'b0;
    tick(12);
    kup = 1'b1;
    tick(10);
    chk("held_thru_reset", cnt0, 1);

    // 2: bounce shorter than the filter
    kup = 1'b0; tick(2);
    kup = 1'b1; tick(2);
    kup = 1'b0; tick(2);
    kup = 1'b1; tick(12);
    chk("bounce", cnt0, 1);

    // 3: short press
    press(1, 10);
    tick(10);
    chk("short_press", cnt0, 2);

    // 4: hold through five auto steps, then release
    base0 = cnt0;
    base1 = cnt1;
    press(1, 58);
    tick(20);
    chk("hold_delta0", (cnt0 - base0 + MOD) % MOD, 6);
    chk("hold_delta1", cnt1 - base1, 6);

    // 5: boundaries
    do_reset();
    press(2, 10); tick(10);
    chk("wrap_down0", cnt0, MOD - 1);
    chk("sat_down1", cnt1, 0);
    press(1, 10); tick(10);
    chk("wrap_up0", cnt0, 0);
    press(1, 7 + HOLD + REP * 16); tick(12);
    chk("sat_up1", cnt1, MOD - 1);
    chk("sat_at_max1", max1, 1);

    // 6: conflict and clear during hold
    base0 = cnt0;
    press(3, 10); tick(10);
    chk("conflict", cnt0, base0);
    do_reset();
    tick(2);
    kup = 1'b0;
    n = 0;
    while (cnt0 != 5 && n < 200) begin tick(1); n++; end
    chk("reach5_timeout", n < 200, 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr", cnt0, 0);
    n = 0;
    while (cnt0 == 0 && n < 50) begin tick(1); n++; end
    chk("after_clr_step", cnt0, 1);
    kup = 1'b1;
    tick(12);

    // Random phase
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1; tick($urandom_range(1, 3)); rst = 1'b0;
      end else if (r < 9) begin
        clr = 1'b1; tick(1); clr = 1'b0;
      end else begin
        kup = ($urandom_range(0, 1) == 1);
        kdn = ($urandom_range(0, 2) != 0);
        tick($urandom_range(1, 40));
      end
    end
    kup = 1'b1;
    kdn = 1'b1;
    clr = 1'b0;
    tick(40);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
